// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, decoder opcodes and the
// data-memory responder state encoding.
package riscv_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 3;

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with synchronous write and registered read; no reset.
module dmem_array
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [XLEN-1:0]          wdata,
   output logic [XLEN-1:0]          rdata
);

   logic [XLEN-1:0] mem [DEPTH];

   // Read returns the pre-write contents on a same-edge write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one word load/store at a time over valid/ready,
// response after LATENCY wait cycles, held until the core accepts it.
module dmem_resp
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int unsigned IW = $clog2(DEPTH);

   dmem_state_e      state;
   logic [CNT_W-1:0] cnt;
   logic             lat_we;
   logic [XLEN-1:0]  lat_addr;
   logic [XLEN-1:0]  lat_wdata;
   logic             rd_ok;

   logic             accept_c;
   logic             access_c;
   logic             acc_we_c;
   logic [XLEN-1:0]  acc_addr_c;
   logic [XLEN-1:0]  acc_wdata_c;
   logic             err_c;
   logic             mem_we_c;
   logic [IW-1:0]    idx_c;
   logic [XLEN-1:0]  arr_rdata;

   // With zero latency the access happens on the accept edge, so the raw
   // request is used; otherwise the latched copy is.
   always_comb begin
      accept_c    = (state == IDLE) && req_valid;
      acc_we_c    = (state == IDLE) ? req_we    : lat_we;
      acc_addr_c  = (state == IDLE) ? req_addr  : lat_addr;
      acc_wdata_c = (state == IDLE) ? req_wdata : lat_wdata;
      access_c    = (LATENCY == 0) ? accept_c : ((state == WAIT) && (cnt == '0));
      err_c       = (acc_addr_c[1:0] != 2'b00) ||
                    (XLEN'(acc_addr_c[XLEN-1:2]) >= XLEN'(DEPTH));
      mem_we_c    = access_c && acc_we_c && !err_c && !reset;
      idx_c       = acc_addr_c[IW+1:2];
   end

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (mem_we_c),
      .idx   (idx_c),
      .wdata (acc_wdata_c),
      .rdata (arr_rdata)
   );

   // Array output is held stable during RESP because idx comes from lat_addr.
   assign rsp_rdata = arr_rdata & {XLEN{rd_ok}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rd_ok     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  req_ready <= 1'b0;
                  if (LATENCY == 0) begin
                     state <= RESP;
                  end else begin
                     cnt   <= CNT_W'(LATENCY - 1);
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  rd_ok     <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Response capture on the access edge
         if (access_c) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_c;
            rd_ok     <= !acc_we_c && !err_c;
         end
      end
   end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the RISC-V core. The main decoder issues loads (`resultsrc`) and stores (`MemWrite`), and this block is the memory side that serves them. It accepts one word-sized load or store request at a time over a valid/ready handshake. After a programmable number of wait cycles it returns a response carrying read data and an error flag, and holds that response until the core accepts it. It sits between the core's datapath (ALU result as address, rs2 as write data) and the word-addressed storage array.

## Interface
Parameters:
- `DEPTH` — default 64 — number of 32-bit words; power of two, 4..4096.
- `LATENCY` — default 2 — wait cycles between accept and response; 0..7.

Ports:
- `clk` — in, 1 — clock; all state updates on rising edge.
- `reset` — in, 1 — asynchronous, active-high reset.
- `req_valid` — in, 1 — request present.
- `req_ready` — out, 1 — block can accept a request.
- `req_we` — in, 1 — 1 = store (from `MemWrite`), 0 = load.
- `req_addr` — in, 32 — byte address.
- `req_wdata` — in, 32 — store data.
- `rsp_valid` — out, 1 — response present.
- `rsp_ready` — in, 1 — core accepts the response.
- `rsp_rdata` — out, 32 — load data; 0 for stores and errors.
- `rsp_err` — out, 1 — misaligned or out-of-range access.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `req_we`, `req_addr`, `req_wdata`.
  - If `LATENCY`=0, go to RESP; otherwise load the counter with `LATENCY`-1 and go to WAIT.
- WAIT:
  - `req_ready`=0.
  - Decrement the counter each cycle.
  - When the counter is 0, perform the access and go to RESP.
- Access, performed on the edge that enters RESP:
  - Error when `addr[1:0]`≠0 or `addr[31:2]`≥`DEPTH`. On error: `rsp_err`=1, `rsp_rdata`=0, no write.
  - Store: `mem[addr[31:2]]` ← `wdata`; `rsp_rdata`=0.
  - Load: `rsp_rdata` ← `mem[addr[31:2]]`, registered.
- RESP:
  - `rsp_valid`=1; `rsp_rdata` and `rsp_err` are held stable until the handshake.
  - `req_ready`=0.
  - When `rsp_ready`=1, go to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- Memory contents are not reset; they are undefined until written.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state=IDLE, counter=0.
- Request accepted in cycle N → `rsp_valid` high in cycle N+1+`LATENCY`.
- Response handshake in cycle M → `req_ready` high in cycle M+1. Minimum request-to-request spacing is `LATENCY`+2 cycles.
- A store is visible to a load whose access edge is later than the store's access edge.
- Reset asserted mid-transaction:
  - All outputs immediately return to reset values.
  - A store whose access edge has not yet occurred is dropped.
  - A store already written remains in memory.
- `rsp_ready` held high before `rsp_valid`: the response completes in its first cycle.
- Address 0 and address 4·(`DEPTH`-1) are valid. Address 4·`DEPTH` is an error.

## Structure
- Shared package/header `riscv_pkg`:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Opcode constants already used by the main decoder (LW 7'b0000011, SW 7'b0100011).
  - `XLEN`=32.
- Sub-module `dmem_array`: single-port synchronous RAM.
  - Ports: `clk`, `we`, `idx`, `wdata`, `rdata`.
  - No reset.
  - Instantiated once; the FSM and error check stay in `dmem_resp`.

## Test plan
- Store then load, default parameters: SW addr 0x10 data 0xDEADBEEF → `rsp_valid` 3 cycles after accept, `rsp_err`=0, `rsp_rdata`=0. Then LW addr 0x10 → `rsp_rdata`=0xDEADBEEF.
- Misaligned access: SW addr 0x13 → `rsp_err`=1. A subsequent LW 0x10 still returns its prior value, so no write occurred.
- Out of range, `DEPTH`=64: LW addr 0x100 → `rsp_err`=1, `rsp_rdata`=0. LW addr 0xFC → `rsp_err`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid`/`rsp_rdata` stable, `req_ready`=0 throughout. Release → `req_ready`=1 the next cycle.
- Latency sweep, `LATENCY`=0 and 7: `rsp_valid` at accept+1 and accept+8 respectively. `req_valid` pulses during WAIT are ignored.
- Reset during WAIT of SW 0x20 ← 0x12345678 → outputs return to reset values immediately. A later LW 0x20 returns the old contents.
